qam_frame_ctrl: RTL and testbench
=================================

# qam_frame_ctrl

Transmit frame scheduler that sequences 4-bit 16-QAM symbols into the modulator's `din_valid`/`din`/`din_ready` port. Each frame is a fixed preamble, a payload pulled from an upstream valid/ready stream, and an idle gap. With pilots compiled in, pilot symbols are also interleaved into the payload. It sits between the symbol source and `qam_mod_top`, so the demodulator sees a deterministic frame structure.

## Interface
Parameters:
- `PREAMBLE_LEN`, default 8: preamble symbols per frame, ≥1.
- `PAYLOAD_LEN`, default 64: payload symbols per frame, ≥1; excludes pilots.
- `GAP_LEN`, default 4: idle cycles after the last symbol is accepted, ≥1.
- `PREAMBLE_SYM0`, default 4'sb0101: preamble symbol at even indices.
- `PREAMBLE_SYM1`, default 4'sb1010: preamble symbol at odd indices.
- `PILOT_PERIOD`, default 16: payload symbols between pilots. Used only with the pilot macro.
- `PILOT_SYM`, default 4'sb0011: pilot symbol. Used only with the pilot macro.

Ports:
- `axi_clk`, in, 1: the only clock.
- `axi_rstn`, in, 1: reset, asynchronous and active-low.
- `tx_en`, in, 1: level enable; sampled only in IDLE.
- `s_valid`, in, 1: upstream payload symbol valid.
- `s_data`, in, 4 signed: upstream payload symbol.
- `s_ready`, out, 1: upstream ready.
- `m_valid`, out, 1: to modulator `din_valid`.
- `m_data`, out, 4 signed: to modulator `din`.
- `m_ready`, in, 1: from modulator `din_ready`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `frame_done`, out, 1: one-cycle pulse at the end of the gap.
- `frame_cnt`, out, 16: completed frames, wraps 0xFFFF→0.

## Operation
- A transfer happens on any cycle with `m_valid && m_ready`.
- Output register rules:
  - The register loads a new symbol on an edge where it is free, i.e. `!m_valid || m_ready`, and the state has a symbol to emit.
  - If the register is free and there is no symbol to emit, `m_valid` clears.
  - `m_data` is held stable while `m_valid && !m_ready`.
- State machine, with states IDLE, PREAMBLE, PAYLOAD, GAP:
  - IDLE → PREAMBLE: `tx_en`=1 at an edge. On that same edge, preamble symbol 0 is loaded and the symbol counter `sym_cnt` is set to 1.
  - PREAMBLE: each free edge loads index `sym_cnt`. Even index loads `PREAMBLE_SYM0`, odd index loads `PREAMBLE_SYM1`. After index `PREAMBLE_LEN`-1 is loaded, go to PAYLOAD with the payload counter `pay_cnt` at 0.
  - PAYLOAD: `s_ready = (state==PAYLOAD) && !pilot_due && (!m_valid || m_ready)`. This is combinational from `m_ready`. On `s_valid && s_ready`, load `s_data` and increment `pay_cnt`. When the load makes `pay_cnt`=`PAYLOAD_LEN`, go to GAP.
  - Upstream underflow in PAYLOAD (`s_valid`=0) is a stall only: no error, and no filler symbol is sent.
  - GAP:
    - The gap counter starts only once the last symbol has transferred, i.e. when `m_valid` is 0.
    - It then counts `GAP_LEN` cycles.
    - On the final gap cycle's edge: pulse `frame_done`, increment `frame_cnt`, go to IDLE.
- Deasserting `tx_en` mid-frame has no effect; the current frame completes.
- Holding `tx_en` high produces frames back to back, separated by the gap plus one IDLE cycle.
- Reset mid-frame: the frame is abandoned immediately, the in-flight `m_valid` drops, and nothing resumes.

## Timing
- Reset values:
  - state = IDLE.
  - `m_valid` = 0, `m_data` = 0, `s_ready` = 0.
  - `busy` = 0, `frame_done` = 0, `frame_cnt` = 0.
- Latency: if `tx_en` is sampled high at edge N, then `m_valid`=1 and `m_data`=`PREAMBLE_SYM0` after edge N.
- Throughput: with `m_ready`=1 and `s_valid`=1 throughout, one symbol is sent per cycle, with no bubble at PREAMBLE→PAYLOAD.
- Payload latency: `s_data` accepted at edge K appears on `m_data` after edge K.
- Counter widths:
  - `sym_cnt`: `$clog2(PREAMBLE_LEN+1)` bits.
  - `pay_cnt`: `$clog2(PAYLOAD_LEN+1)` bits.
  - gap counter: `$clog2(GAP_LEN+1)` bits.
- `frame_cnt` wraps with no saturation.

## Configuration
- Macro: `QAM_FRAME_PILOT_EN`.
- Defined:
  - `pilot_due` is set when `pay_cnt`>0, `pay_cnt % PILOT_PERIOD`==0, `pay_cnt`<`PAYLOAD_LEN`, and the pilot for that `pay_cnt` has not yet been sent.
  - While `pilot_due` is set, `s_ready`=0 and the next free edge loads `PILOT_SYM`.
  - Pilots do not count in `pay_cnt`.
  - No pilot is sent after the final payload symbol.
- Undefined: `pilot_due` is tied to 0; `PILOT_PERIOD` and `PILOT_SYM` are ignored.

## Structure
- Shared package `qam_pkg` holds:
  - `typedef logic signed [3:0] sym_t`.
  - The state enum `frame_state_t`.
  - Default preamble and pilot symbol constants.
- Sub-module `qam_sym_reg` is the one-entry valid/ready output register. Ports: `load`, `load_data`, `free`, `m_valid`, `m_data`, `m_ready`.

## Test plan
Bench parameters: `PREAMBLE_LEN`=4, `PAYLOAD_LEN`=8, `GAP_LEN`=3, `PILOT_PERIOD`=4.
- Basic frame: `tx_en` pulsed for 1 cycle, `m_ready`=1, `s_valid`=1 with data 1..8.
  - Required: `m_data` = 5,−6,5,−6,1,2,…,8 on 12 consecutive cycles.
  - Then 3 idle cycles, one `frame_done` pulse, `frame_cnt`=1.
- Backpressure: `m_ready` toggling 1,0,1,0.
  - Required: `m_data` stable whenever `m_valid && !m_ready`; 12 transfers total; same symbol order as the basic frame.
- Underflow: `s_valid`=0 for 5 cycles after the 3rd payload symbol.
  - Required: `m_valid` drops during the stall, no extra symbols, `busy` stays 1.
  - The frame completes with exactly 8 payload symbols.
- Pilot, with `QAM_FRAME_PILOT_EN`:
  - Required payload-phase output: 1,2,3,4,3,5,6,7,8, i.e. a pilot after symbol 4 and no pilot after symbol 8.
- Reset and wrap:
  - Assert `axi_rstn`=0 during the payload. Required: all outputs reach reset values at once.
  - Force `frame_cnt`=0xFFFF, then run one frame. Required: `frame_cnt` reads 0.
- Continuous frames: `tx_en` held at 1 for 3 frames.
  - Required: gap of 3 cycles plus 1 IDLE cycle between frames; `frame_cnt`=3.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and default symbol constants for the QAM transmit frame path.
package qam_pkg;

  typedef logic signed [3:0] sym_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_GAP
  } frame_state_t;

  localparam sym_t PREAMBLE_SYM0_DEF = 4'sb0101;
  localparam sym_t PREAMBLE_SYM1_DEF = 4'sb1010;
  localparam sym_t PILOT_SYM_DEF     = 4'sb0011;

endpackage

// File: rtl/qam_sym_reg.sv
// One-entry valid/ready output register feeding the modulator symbol port.
module qam_sym_reg
  import qam_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  sym_t load_data,
  output logic free,
  output logic m_valid,
  output sym_t m_data,
  input  logic m_ready
);

  logic m_valid_q, m_valid_d;
  sym_t m_data_q, m_data_d;

  assign free    = !m_valid_q || m_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

  // Refill or drain when the slot is free; hold the symbol while stalled.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (free) begin
      m_valid_d = load;
      if (load) m_data_d = load_data;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: rtl/qam_frame_ctrl.sv
// Transmit frame scheduler: preamble, upstream payload, idle gap.
// Optional pilot interleaving is compiled in with QAM_FRAME_PILOT_EN.
module qam_frame_ctrl
  import qam_pkg::*;
#(
  parameter int   PREAMBLE_LEN  = 8,
  parameter int   PAYLOAD_LEN   = 64,
  parameter int   GAP_LEN       = 4,
  parameter sym_t PREAMBLE_SYM0 = PREAMBLE_SYM0_DEF,
  parameter sym_t PREAMBLE_SYM1 = PREAMBLE_SYM1_DEF,
  parameter int   PILOT_PERIOD  = 16,
  parameter sym_t PILOT_SYM     = PILOT_SYM_DEF
) (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        tx_en,
  input  logic        s_valid,
  input  sym_t        s_data,
  output logic        s_ready,
  output logic        m_valid,
  output sym_t        m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int SYM_W = $clog2(PREAMBLE_LEN + 1);
  localparam int PAY_W = $clog2(PAYLOAD_LEN + 1);
  localparam int GAP_W = $clog2(GAP_LEN + 1);

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(PREAMBLE_LEN - 1);
  localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

`ifdef QAM_FRAME_PILOT_EN
  localparam bit PILOT_ON = 1'b1;
`else
  localparam bit PILOT_ON = 1'b0;
`endif

  frame_state_t     state_q, state_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [PAY_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             pilot_sent_q, pilot_sent_d;

  logic free, load, pilot_due;
  sym_t load_data;

  // A pilot is owed at every PILOT_PERIOD boundary inside the payload, once.
  assign pilot_due = PILOT_ON && (state_q == ST_PAYLOAD) && (pay_cnt_q != '0) &&
                     ((int'(pay_cnt_q) % PILOT_PERIOD) == 0) &&
                     (int'(pay_cnt_q) < PAYLOAD_LEN) && !pilot_sent_q;

  assign s_ready    = (state_q == ST_PAYLOAD) && !pilot_due && free;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Next-state, counters and output-register load selection.
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    pilot_sent_d = pilot_sent_q;
    load         = 1'b0;
    load_data    = '0;
    case (state_q)
      ST_IDLE: begin
        if (tx_en) begin
          load         = 1'b1;
          load_data    = PREAMBLE_SYM0;
          sym_cnt_d    = SYM_W'(1);
          pay_cnt_d    = '0;
          pilot_sent_d = 1'b0;
          // A one-symbol preamble is complete with this load.
          state_d      = (PREAMBLE_LEN == 1) ? ST_PAYLOAD : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (free) begin
          load      = 1'b1;
          load_data = sym_cnt_q[0] ? PREAMBLE_SYM1 : PREAMBLE_SYM0;
          sym_cnt_d = sym_cnt_q + 1'b1;
          if (sym_cnt_q == SYM_LAST) begin
            state_d   = ST_PAYLOAD;
            pay_cnt_d = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pilot_due) begin
          if (free) begin
            load         = 1'b1;
            load_data    = PILOT_SYM;
            pilot_sent_d = 1'b1;
          end
        end else if (s_valid && s_ready) begin
          load         = 1'b1;
          load_data    = s_data;
          pay_cnt_d    = pay_cnt_q + 1'b1;
          pilot_sent_d = 1'b0;
          if (pay_cnt_q == PAY_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        // Gap timing begins only after the last symbol has left the register.
        if (!m_valid) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (gap_cnt_q == GAP_LAST) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame state and counters.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q      <= ST_IDLE;
      sym_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      pilot_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      pilot_sent_q <= pilot_sent_d;
    end
  end

  qam_sym_reg u_sym_reg (
    .clk       (axi_clk),
    .rst_n     (axi_rstn),
    .load      (load),
    .load_data (load_data),
    .free      (free),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Scoreboard bench for qam_frame_ctrl: stimulus pushes expected symbols,
// a negedge monitor pops and compares on every m_valid && m_ready.
module tb_qam_frame_ctrl;
  import qam_pkg::*;

  localparam int PRE = 4;
  localparam int PAY = 8;
  localparam int GAP = 3;
  localparam int PP  = 4;
`ifdef QAM_FRAME_PILOT_EN
  localparam int FLEN = PRE + PAY + 1;
`else
  localparam int FLEN = PRE + PAY;
`endif

  logic        axi_clk = 1'b0;
  logic        axi_rstn = 1'b0;
  logic        tx_en = 1'b0;
  logic        s_valid = 1'b0;
  sym_t        s_data = '0;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid, busy, frame_done;
  sym_t        m_data;
  logic [15:0] frame_cnt;

  always #5 axi_clk = ~axi_clk;

  qam_frame_ctrl #(
    .PREAMBLE_LEN (PRE),
    .PAYLOAD_LEN  (PAY),
    .GAP_LEN      (GAP),
    .PILOT_PERIOD (PP)
  ) dut (
    .axi_clk    (axi_clk),
    .axi_rstn   (axi_rstn),
    .tx_en      (tx_en),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  int   errors = 0, checks = 0, cyc = 0;
  int   done_cnt = 0, done_cyc = 0, xfer_cnt = 0, first_xfer = -1, last_xfer = 0;
  int   src_idx = 0, stall_left = 0, low_run = 0;
  bit   s_hs = 0, stall_act = 0, stall_low = 0, seen_valid = 0, prev_hold = 0, rec_gaps = 0;
  sym_t prev_data = '0;
  sym_t exp_q[$];
  int   gap_runs[$];

  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame: preamble 5,-6,5,-6 then payload 1..8 (pilot 3 after 4).
  task automatic push_frame();
    for (int i = 0; i < PRE; i++) exp_q.push_back((i % 2) ? -4'sd6 : 4'sd5);
    for (int i = 1; i <= PAY; i++) begin
      exp_q.push_back(sym_t'(i));
`ifdef QAM_FRAME_PILOT_EN
      if ((i % PP) == 0 && i < PAY) exp_q.push_back(4'sd3);
`endif
    end
  endtask

  // Monitor: scoreboard pop, hold stability, frame_done and gap tracking.
  always @(negedge axi_clk) begin
    if (!axi_rstn) begin
      prev_hold = 0;
      s_hs      = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      s_hs      = s_valid && s_ready;
      if (m_valid && m_ready) begin
        chk("sym_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("m_data", m_data, exp_q.pop_front());
        xfer_cnt++;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_act) begin
        chk("stall_busy", busy, 1);
        if (!m_valid) stall_low = 1;
      end
      if (m_valid) begin
        if (seen_valid && low_run > 0 && rec_gaps) gap_runs.push_back(low_run);
        seen_valid = 1;
        low_run    = 0;
      end else begin
        low_run++;
      end
    end
  end

  // One driver step, called just after a rising edge.
  task automatic step(input int mrmode);
    if (s_hs) src_idx++;
    if (src_idx == PAY) src_idx = 0;
    m_ready   = (mrmode == 0) ? 1'b1 : ~m_ready;
    stall_act = (src_idx == 3) && (stall_left > 0);
    if (stall_act) begin
      s_valid = 1'b0;
      stall_left--;
    end else begin
      s_valid = 1'b1;
    end
    s_data = sym_t'(src_idx + 1);
  endtask

  task automatic run(input int nfr, input int mrmode, input int stall, input bit hold);
    int target;
    target = done_cnt + nfr;
    for (int f = 0; f < nfr; f++) push_frame();
    stall_left = stall; stall_low = 0; src_idx = 0; xfer_cnt = 0; first_xfer = -1;
    seen_valid = 0; low_run = 0; gap_runs.delete(); rec_gaps = hold;
    m_ready = 1'b1; s_valid = 1'b0; tx_en = 1'b1;
    for (int k = 0; k < 3000 && done_cnt < target; k++) begin
      @(posedge axi_clk); #1;
      if (k == 0) begin
        chk("latency_valid", m_valid, 1);
        chk("latency_data", m_data, 5);
        chk("busy_start", busy, 1);
      end
      if (!hold || (done_cnt >= target - 1 && busy)) tx_en = 1'b0;
      step(mrmode);
    end
    if (done_cnt < target) chk("frame_timeout", done_cnt, target);
    tx_en = 1'b0;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("done_pulses", done_cnt, target);
    chk("busy_idle", busy, 0);
    chk("xfers", xfer_cnt, nfr * FLEN);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    axi_rstn = 1'b1;
    @(posedge axi_clk); #1;

    // Basic frame
    run(1, 0, 0, 0);
    chk("basic_frame_cnt", frame_cnt, 1);
    chk("basic_consecutive", last_xfer - first_xfer, FLEN - 1);
    chk("basic_gap_to_done", done_cyc - last_xfer, GAP + 1);

    // Backpressure
    run(1, 1, 0, 0);
    chk("bp_frame_cnt", frame_cnt, 2);

    // Underflow stall of 5 cycles after the 3rd payload symbol
    run(1, 0, 5, 0);
    chk("stall_valid_drop", stall_low, 1);
    chk("stall_frame_cnt", frame_cnt, 3);

    // Reset during payload
    push_frame();
    src_idx = 0; stall_left = 0; m_ready = 1'b1; tx_en = 1'b1;
    for (int k = 0; k < 100 && src_idx < 2; k++) begin
      @(posedge axi_clk); #1;
      tx_en = 1'b0;
      step(0);
    end
    chk("rst_reached_payload", src_idx >= 2, 1);
    axi_rstn = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    @(posedge axi_clk); #2;
    axi_rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge axi_clk);
      chk("no_resume_valid", m_valid, 0);
      chk("no_resume_busy", busy, 0);
    end
    @(posedge axi_clk); #1;

    // Continuous frames with tx_en held high
    run(3, 0, 0, 1);
    chk("cont_frame_cnt", frame_cnt, 3);
    chk("cont_gap_count", gap_runs.size(), 2);
    for (int i = 0; i < gap_runs.size(); i++) chk("cont_gap_len", gap_runs[i], GAP + 1);

    // frame_cnt wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge axi_clk); #1;
    release dut.frame_cnt_q;
    @(posedge axi_clk); #1;
    run(1, 0, 0, 0);
    chk("wrap_frame_cnt", frame_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
